// File: rtl/deinterleave_block_output.sv
// deinterleave_block_output
//   Reassembles blocks of N samples that arrive interleaved sample-by-sample
//   over IIR slots, then streams each completed block out contiguously, in
//   completion order, over a valid/ready handshake.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   in_valid                sample present this cycle
//   in_block_start          sample is element 0 of a new block
//   in_slot                 slot tag of the sample
//   data_in                 sample value
//   out_ready               consumer accepts data_out this cycle
//   out_valid               data_out holds a valid sample
//   block_start/block_end   data_out is element 0 / element N-1
//   data_out                sample value
//   out_index               element index of data_out (optional)
//   error                   sticky protocol error, cleared only by reset
//
// Optional feature: define DEINTERLEAVE_OUT_INDEX_EN to add out_index.
module deinterleave_block_output #(
  parameter int BITS = 8,
  parameter int IIR  = 3,
  parameter int N    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_block_start,
  input  logic [$clog2(IIR)-1:0] in_slot,
  input  logic [BITS-1:0]        data_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic                   block_start,
  output logic                   block_end,
  output logic [BITS-1:0]        data_out,
`ifdef DEINTERLEAVE_OUT_INDEX_EN
  output logic [$clog2(N)-1:0]   out_index,
`endif
  output logic                   error
);
  localparam int SW  = $clog2(IIR);
  localparam int IW  = $clog2(N);
  localparam int CW  = $clog2(N) + 1;
  localparam int FCW = $clog2(IIR + 1);
  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [IW-1:0] LAST     = IW'(N - 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(IIR - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_READ} slot_st_e;
  typedef enum logic {R_IDLE, R_READ} rd_st_e;

  logic [BITS-1:0] mem_q [IIR][N];
  slot_st_e        slot_st_q [IIR];
  logic [CW-1:0]   wcnt_q [IIR];

  // completion FIFO of slot ids
  logic [SW-1:0]   fifo_q [IIR];
  logic [SW-1:0]   wptr_q, rptr_q;
  logic [FCW-1:0]  fcnt_q;

  rd_st_e          rd_st_q, rd_st_d;
  logic [SW-1:0]   cur_q, cur_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ov_q, ov_d, bs_q, bs_d, be_q, be_d, err_q;
  logic [BITS-1:0] dout_q, dout_d;

  function automatic logic [SW-1:0] nxt(input logic [SW-1:0] p);
    return (p == SLOT_MAX) ? '0 : p + 1'b1;
  endfunction

  // ---------------- input side decode ----------------
  logic          wr_en, st_wr, push, err_set;
  logic [IW-1:0] wr_addr;
  logic [CW-1:0] cnt_new, wc_inc;
  slot_st_e      st_new;

  always_comb begin
    wr_en   = 1'b0;
    st_wr   = 1'b0;
    push    = 1'b0;
    err_set = 1'b0;
    wr_addr = '0;
    cnt_new = '0;
    st_new  = S_IDLE;
    wc_inc  = '0;
    if (in_valid) begin
      if (in_slot > SLOT_MAX) begin
        err_set = 1'b1;           // nonexistent slot: drop
      end else begin
        wc_inc = wcnt_q[in_slot] + 1'b1;
        case (slot_st_q[in_slot])
          S_IDLE: begin
            if (in_block_start) begin
              wr_en = 1'b1; st_wr = 1'b1; cnt_new = CW'(1); st_new = S_FILL;
            end else begin
              err_set = 1'b1;
            end
          end
          S_FILL: begin
            wr_en = 1'b1;
            st_wr = 1'b1;
            if (in_block_start) begin
              // restart: partial block is overwritten from element 0
              cnt_new = CW'(1); st_new = S_FILL; err_set = 1'b1;
            end else begin
              wr_addr = wcnt_q[in_slot][IW-1:0];
              cnt_new = wc_inc;
              push    = (wc_inc == N_CNT);
              st_new  = push ? S_DONE : S_FILL;
            end
          end
          default: err_set = 1'b1;  // DONE / READING: slot busy, drop
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[in_slot][wr_addr] <= data_in;
  end

  // ---------------- reader FSM ----------------
  logic          fifo_ne, pop, rel;
  logic [SW-1:0] head;
  logic [IW-1:0] idx_inc;

  assign fifo_ne = (fcnt_q != '0);
  assign head    = fifo_q[rptr_q];
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    rd_st_d = rd_st_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    ov_d    = ov_q;
    bs_d    = bs_q;
    be_d    = be_q;
    dout_d  = dout_q;
    pop     = 1'b0;
    rel     = 1'b0;
    case (rd_st_q)
      R_IDLE: begin
        if (fifo_ne) pop = 1'b1;
      end
      R_READ: begin
        if (ov_q && out_ready) begin
          if (idx_q == LAST) begin
            rel = 1'b1;
            if (fifo_ne) begin
              pop = 1'b1;           // back-to-back block, no bubble
            end else begin
              rd_st_d = R_IDLE;
              ov_d = 1'b0; bs_d = 1'b0; be_d = 1'b0;
              idx_d = '0; dout_d = '0;
            end
          end else begin
            idx_d  = idx_inc;
            dout_d = mem_q[cur_q][idx_inc];
            bs_d   = 1'b0;
            be_d   = (idx_inc == LAST);
          end
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
    if (pop) begin
      rd_st_d = R_READ;
      cur_d   = head;
      idx_d   = '0;
      dout_d  = mem_q[head][0];
      ov_d    = 1'b1;
      bs_d    = 1'b1;
      be_d    = 1'b0;
    end
  end

  // Slot-state writers never collide: input only changes IDLE/FILLING slots,
  // pop only DONE slots, release only the READING slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_st_q <= R_IDLE;
      cur_q   <= '0;
      idx_q   <= '0;
      ov_q    <= 1'b0;
      bs_q    <= 1'b0;
      be_q    <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fcnt_q  <= '0;
      for (int i = 0; i < IIR; i++) begin
        slot_st_q[i] <= S_IDLE;
        wcnt_q[i]    <= '0;
        fifo_q[i]    <= '0;
      end
    end else begin
      rd_st_q <= rd_st_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      ov_q    <= ov_d;
      bs_q    <= bs_d;
      be_q    <= be_d;
      dout_q  <= dout_d;
      if (st_wr) begin
        slot_st_q[in_slot] <= st_new;
        wcnt_q[in_slot]    <= cnt_new;
      end
      if (push) begin
        fifo_q[wptr_q] <= in_slot;
        wptr_q         <= nxt(wptr_q);
      end
      if (pop) begin
        slot_st_q[head] <= S_READ;
        rptr_q          <= nxt(rptr_q);
      end
      if (rel) slot_st_q[cur_q] <= S_IDLE;
      fcnt_q <= fcnt_q + FCW'(push) - FCW'(pop);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign out_valid   = ov_q;
  assign block_start = bs_q;
  assign block_end   = be_q;
  assign data_out    = dout_q;
  assign error       = err_q;
`ifdef DEINTERLEAVE_OUT_INDEX_EN
  assign out_index   = idx_q;
`endif

endmodule
